// File: rtl/sprite_write_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_write_scheduler
//
// Buffers sprite-update write requests from the instruction decoder in an
// 8-entry FIFO. It commits them to the register bank or the sprite memory only
// while the print pipeline is idle (vertical blanking), so frame contents never
// change in the middle of a scan.
//
// Ports
//   clk         system clock, the only clock of the block
//   reset       asynchronous, active-low reset
//   printting   print-module status (1 = scanning), from the clk_pixel domain
//   req_valid   decoder presents a request
//   req_ready   FIFO can accept a request (combinational from occupancy)
//   req_sel     0 = register-bank write, 1 = sprite-memory write
//   req_addr    target address (register index is the low 5 bits)
//   req_data    write data
//   reg_wr      register-bank write strobe (1-cycle pulse)
//   reg_addr    register index
//   reg_data    register write data
//   mem_wr      sprite-memory write strobe (1-cycle pulse)
//   mem_addr    sprite-memory address
//   mem_data    sprite-memory write data
//   fifo_count  FIFO occupancy, 0..DEPTH
//   busy        1 whenever the commit FSM is not idle
// ---------------------------------------------------------------------------
module sprite_write_scheduler #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  printting,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sel,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  reg_wr,
  output logic [4:0]            reg_addr,
  output logic [DATA_W-1:0]     reg_data,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Synchronizer
  logic r_sync1;
  logic r_sync2;
  logic w_blank;

  // FIFO storage and bookkeeping
  logic                  r_fifo_sel  [DEPTH];
  logic [ADDR_W-1:0]     r_fifo_addr [DEPTH];
  logic [DATA_W-1:0]     r_fifo_data [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_ready;
  logic w_push;
  logic w_pop;

  // Commit FSM and output holding registers
  state_t              r_state;
  logic                r_sel;
  logic                r_reg_wr;
  logic                r_mem_wr;
  logic [4:0]          r_reg_addr;
  logic [DATA_W-1:0]   r_reg_data;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data;
  logic                r_busy;

  logic                w_head_sel;
  logic [ADDR_W-1:0]   w_head_addr;
  logic [DATA_W-1:0]   w_head_data;

  // -------------------------------------------------------------------------
  // printting crosses from clk_pixel. Both flops reset to 1 so that a block
  // coming out of reset assumes a scan is in progress and never writes until
  // blanking has actually been observed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= printting;
      r_sync2 <= r_sync1;
    end
  end

  assign w_blank = ~r_sync2;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  assign w_ready = (r_count != CNT_FULL);
  assign w_push  = req_valid && w_ready;

  // The head entry is popped on the edge that enters LOAD, so the holding
  // registers (and fifo_count) already show the new entry during LOAD.
  assign w_pop = ((r_state == S_IDLE) || (r_state == S_HOLD)) &&
                 w_blank && (r_count != CNT_ZERO);

  assign w_head_sel  = r_fifo_sel[r_rd_ptr];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Storage is plain data: it is only ever read behind a valid count, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_sel[r_wr_ptr]  <= req_sel;
      r_fifo_addr[r_wr_ptr] <= req_addr;
      r_fifo_data[r_wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Commit FSM: IDLE -> LOAD -> WRITE -> HOLD -> (LOAD | IDLE).
  // Blanking is only examined in IDLE and HOLD, so a commit that has started
  // always runs to completion even if scanning resumes meanwhile.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          r_reg_wr <= 1'b0;
          r_mem_wr <= 1'b0;
          if (w_pop) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_sel      <= w_head_sel;
            // Both port groups carry the entry; only the strobe differs.
            r_reg_addr <= w_head_addr[4:0];
            r_reg_data <= w_head_data;
            r_mem_addr <= w_head_addr;
            r_mem_data <= w_head_data;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        S_LOAD: begin
          r_state  <= S_WRITE;
          r_busy   <= 1'b1;
          r_reg_wr <= ~r_sel;
          r_mem_wr <= r_sel;
        end

        S_WRITE: begin
          r_state  <= S_HOLD;
          r_busy   <= 1'b1;
          r_reg_wr <= 1'b0;
          r_mem_wr <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_reg_wr <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign reg_wr     = r_reg_wr;
  assign reg_addr   = r_reg_addr;
  assign reg_data   = r_reg_data;
  assign mem_wr     = r_mem_wr;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign fifo_count = r_count;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sprite_write_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for sprite_write_scheduler. Accepted requests are pushed to an
// expected queue as they are driven; observed strobes are collected into an
// observed queue and compared in order by each scenario task.
// ---------------------------------------------------------------------------
module tb_sprite_write_scheduler;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 14;
  localparam int DEPTH_LOG2 = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                printting = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic                req_sel = 1'b0;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [DATA_W-1:0]   req_data = '0;
  logic                reg_wr;
  logic [4:0]          reg_addr;
  logic [DATA_W-1:0]   reg_data;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                busy;

  always #5 clk = ~clk;

  sprite_write_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk(clk), .reset(reset), .printting(printting),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_addr(req_addr), .req_data(req_data),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .fifo_count(fifo_count), .busy(busy)
  );

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
    logic              pre_ok;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic last_acc = 1'b0;
  logic both_hi  = 1'b0;
  logic [ADDR_W-1:0] prev_maddr = '0;
  logic [DATA_W-1:0] prev_mdata = '0;

  // One clock: record an accepted request as expected, record any strobe.
  task automatic step();
    logic acc;
    ev_t  e;
    ev_t  o;
    acc      = reset && req_valid && req_ready;
    e.sel    = req_sel;
    e.addr   = req_sel ? req_addr : {{(ADDR_W-5){1'b0}}, req_addr[4:0]};
    e.data   = req_data;
    e.cyc    = 0;
    e.pre_ok = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    if (acc) exp_q.push_back(e);
    if (reg_wr && mem_wr) both_hi = 1'b1;
    if (reg_wr || mem_wr) begin
      o.sel  = mem_wr;
      o.addr = mem_wr ? mem_addr : {{(ADDR_W-5){1'b0}}, reg_addr};
      o.data = mem_wr ? mem_data : reg_data;
      o.cyc  = cyc;
      // address/data must already have been present in the LOAD cycle, and
      // both port groups must agree
      o.pre_ok = (prev_maddr == mem_addr) && (prev_mdata == mem_data) &&
                 (reg_addr == mem_addr[4:0]) && (reg_data == mem_data);
      obs_q.push_back(o);
    end
    prev_maddr = mem_addr;
    prev_mdata = mem_data;
  endtask

  task automatic push(input logic s, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    int b;
    req_valid = 1'b1; req_sel = s; req_addr = a; req_data = d;
    b = 0;
    do begin
      step();
      b++;
    end while (!last_acc && b < 20);
    req_valid = 1'b0;
    total++;
    if (last_acc !== 1'b1) begin
      bad++;
      $display("FAIL push_accept got=%0b want=1 addr=%0d", last_acc, a);
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    int b;
    b = budget;
    while (obs_q.size() < n && b > 0) begin
      step();
      b--;
    end
  endtask

  task automatic idle_scan();
    printting = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) begin
      printting = 1'($urandom_range(0, 1));
      req_valid = 1'($urandom_range(0, 1));
      req_sel   = 1'($urandom_range(0, 1));
      req_addr  = ADDR_W'($urandom);
      req_data  = $urandom;
      step();
    end
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL rst_reg_wr got=%b want=0", reg_wr); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%b want=0", mem_wr); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (mem_addr !== '0 || mem_data !== '0 || reg_addr !== '0 || reg_data !== '0) begin
      bad++; $display("FAIL rst_outputs got=%h/%h/%h/%h want=0", mem_addr, mem_data, reg_addr, reg_data);
    end
    req_valid = 1'b0;
    printting = 1'b1;
    reset     = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
    exp_q.delete();
    obs_q.delete();
    repeat (3) step();
  endtask

  task automatic test_push_scan();
    int  c0;
    ev_t o, e;
    push(1'b0, 14'd5,   32'hAAAA_0001);
    push(1'b1, 14'd100, 32'hBBBB_0002);
    push(1'b0, 14'd7,   32'hCCCC_0003);
    repeat (3) step();
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL scan_no_strobe got=%0d want=0", obs_q.size()); end
    total++; if (fifo_count !== 4'd3) begin bad++; $display("FAIL scan_count got=%0d want=3", fifo_count); end
    printting = 1'b0;
    c0 = cyc;
    wait_obs(3, 40);
    total++;
    if (obs_q.size() !== 3) begin
      bad++; $display("FAIL scan_commits got=%0d want=3", obs_q.size());
    end else begin
      total++; if (obs_q[0].cyc !== c0 + 4) begin bad++; $display("FAIL scan_latency got=%0d want=%0d", obs_q[0].cyc - c0, 4); end
      total++; if (obs_q[1].cyc - obs_q[0].cyc !== 3) begin bad++; $display("FAIL scan_gap1 got=%0d want=3", obs_q[1].cyc - obs_q[0].cyc); end
      total++; if (obs_q[2].cyc - obs_q[1].cyc !== 3) begin bad++; $display("FAIL scan_gap2 got=%0d want=3", obs_q[2].cyc - obs_q[1].cyc); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o.sel !== e.sel || o.addr !== e.addr || o.data !== e.data || o.pre_ok !== 1'b1) begin
        bad++;
        $display("FAIL scan_entry got sel=%0b addr=%0d data=%h stable=%0b want sel=%0b addr=%0d data=%h",
                 o.sel, o.addr, o.data, o.pre_ok, e.sel, e.addr, e.data);
      end
    end
    repeat (3) step();
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL scan_end_count got=%0d want=0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_full();
    ev_t o, e;
    idle_scan();
    for (int i = 0; i < 8; i++) push(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", fifo_count); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", req_ready); end
    req_valid = 1'b1; req_sel = 1'b1; req_addr = 14'h2A5A; req_data = 32'h9999_0009;
    repeat (3) step();
    total++; if (exp_q.size() !== 8 || fifo_count !== 4'd8) begin
      bad++; $display("FAIL full_hold got=%0d/%0d want=8/8", exp_q.size(), fifo_count);
    end
    printting = 1'b0;
    for (int b = 0; b < 120 && obs_q.size() < 9; b++) begin
      step();
      if (last_acc) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    total++;
    if (obs_q.size() !== 9) begin
      bad++; $display("FAIL full_commits got=%0d want=9", obs_q.size());
    end else begin
      for (int i = 1; i < 9; i++) begin
        total++;
        if (obs_q[i].cyc - obs_q[i-1].cyc !== 3) begin
          bad++; $display("FAIL full_gap%0d got=%0d want=3", i, obs_q[i].cyc - obs_q[i-1].cyc);
        end
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o.sel !== e.sel || o.addr !== e.addr || o.data !== e.data || o.pre_ok !== 1'b1) begin
        bad++;
        $display("FAIL full_entry got sel=%0b addr=%0d data=%h stable=%0b want sel=%0b addr=%0d data=%h",
                 o.sel, o.addr, o.data, o.pre_ok, e.sel, e.addr, e.data);
      end
    end
    repeat (3) step();
    total++; if (fifo_count !== 4'd0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL full_drain got=%0d/%0d want=0/0", fifo_count, exp_q.size());
    end
  endtask

  task automatic test_midcommit();
    ev_t o, e;
    idle_scan();
    for (int i = 0; i < 4; i++) push(1'(i), ADDR_W'($urandom), $urandom);
    printting = 1'b0;
    wait_obs(1, 20);
    step();             // HOLD of entry 1
    step();             // LOAD of entry 2
    printting = 1'b1;   // synchronized value rises while entry 2 is in WRITE
    wait_obs(2, 10);
    repeat (6) step();
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL mid_committed got=%0d want=2", obs_q.size()); end
    total++; if (fifo_count !== 4'd2) begin bad++; $display("FAIL mid_count got=%0d want=2", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    printting = 1'b0;
    wait_obs(4, 40);
    total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL mid_resume got=%0d want=4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o.sel !== e.sel || o.addr !== e.addr || o.data !== e.data || o.pre_ok !== 1'b1) begin
        bad++;
        $display("FAIL mid_entry got sel=%0b addr=%0d data=%h stable=%0b want sel=%0b addr=%0d data=%h",
                 o.sel, o.addr, o.data, o.pre_ok, e.sel, e.addr, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    logic [DEPTH_LOG2:0] cb;
    idle_scan();
    push(1'b1, 14'd300, 32'h1111_0001);
    push(1'b0, 14'd17,  32'h2222_0002);
    printting = 1'b0;
    wait_obs(1, 20);
    step();             // HOLD: the next edge pops entry 2
    cb = fifo_count;
    req_valid = 1'b1; req_sel = 1'b1; req_addr = 14'd4000; req_data = 32'h3333_0003;
    step();
    req_valid = 1'b0;
    total++; if (last_acc !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", last_acc); end
    total++; if (fifo_count !== cb) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", fifo_count, cb); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    wait_obs(3, 30);
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL b2b_commits got=%0d want=3", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o.sel !== e.sel || o.addr !== e.addr || o.data !== e.data || o.pre_ok !== 1'b1) begin
        bad++;
        $display("FAIL b2b_entry got sel=%0b addr=%0d data=%h stable=%0b want sel=%0b addr=%0d data=%h",
                 o.sel, o.addr, o.data, o.pre_ok, e.sel, e.addr, e.data);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    ev_t o, e;
    idle_scan();
    push(1'b0, 14'd9,   32'h4444_0004);
    push(1'b1, 14'd500, 32'h5555_0005);
    printting = 1'b0;
    wait_obs(1, 20);
    total++;
    if (obs_q.size() !== 1 || exp_q.size() === 0) begin
      bad++; $display("FAIL rmid_first got=%0d want=1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (o.sel !== e.sel || o.addr !== e.addr || o.data !== e.data) begin
        bad++; $display("FAIL rmid_entry got addr=%0d data=%h want addr=%0d data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    reset = 1'b0;       // asserted while the strobe is high
    #1;
    total++; if (reg_wr !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL rmid_strobe got=%b%b want=00", reg_wr, mem_wr); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    exp_q.delete();
    repeat (2) step();
    reset = 1'b1;
    repeat (20) step();
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL rmid_no_write got=%0d want=0", obs_q.size()); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rmid_count_after got=%0d want=0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_push_scan();
    test_full();
    test_midcommit();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (both_hi !== 1'b0) begin
      bad++; $display("FAIL both_strobes got=%b want=0", both_hi);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_write_scheduler.md
# sprite_write_scheduler

- Buffers sprite-update write requests from the instruction decoder in a small FIFO.
- Commits each request to the register bank or the sprite memory only while the print pipeline is idle (`printting` = 0, vertical blanking), so frame contents never change mid-scan.
- Sits between the instruction decoder and the shared register bank / sprite memory write ports.
- Runs on the system clock `clk`.

## Interface
Parameters:
- `DATA_W`, 32, width of write data
- `ADDR_W`, 14, sprite memory address width; the register address is its low 5 bits
- `DEPTH_LOG2`, 3, log2 of FIFO depth (depth 8)

Ports:
- `clk`  in  1  system clock; the only clock in the block
- `reset`  in  1  asynchronous, active-low reset
- `printting`  in  1  print-module status, 1 = scanning active lines; from the `clk_pixel` domain
- `req_valid`  in  1  decoder presents a request
- `req_ready`  out  1  FIFO can accept a request
- `req_sel`  in  1  0 = register-bank write, 1 = sprite-memory write
- `req_addr`  in  ADDR_W  target address
- `req_data`  in  DATA_W  write data
- `reg_wr`  out  1  register-bank write strobe
- `reg_addr`  out  5  register index, equal to `req_addr[4:0]`
- `reg_data`  out  DATA_W  register write data
- `mem_wr`  out  1  sprite-memory write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_data`  out  DATA_W  memory write data
- `fifo_count`  out  DEPTH_LOG2+1  occupancy, 0..8
- `busy`  out  1  1 whenever the FSM is not in IDLE

## Operation
- **Synchronizer:** `printting` passes through a 2-flop synchronizer. `blank` = NOT synchronized value.
- **FIFO:** circular buffer, 8 entries of {`sel`, `addr`, `data`}.
  - Push when `req_valid` && `req_ready`.
  - `req_ready` = (`fifo_count` != 8), purely combinational from count.
  - Write and read pointers are DEPTH_LOG2 bits and wrap 7→0.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push while full cannot occur, because ready = 0. The decoder holds its request.
- **FSM states:**
  - IDLE: go to LOAD if `blank` && count != 0; otherwise stay.
  - LOAD: pop the head entry into output holding registers (addr/data onto both port groups). Go to WRITE.
  - WRITE: assert exactly one strobe for one cycle (`reg_wr` if sel = 0, `mem_wr` if sel = 1). Go to HOLD.
  - HOLD: strobes low, addr/data held. Go to LOAD if `blank` && count != 0, else IDLE.
- **`printting` rising mid-commit:** a commit already in LOAD/WRITE/HOLD always completes. Blanking is checked only in IDLE and HOLD.
- **Draining:** entries commit strictly in FIFO order, one per 3 cycles, until the FIFO empties or `blank` falls.
- **Reset values** (asynchronous, `reset` = 0):
  - State IDLE, pointers 0, `fifo_count` 0, synchronizer flops 1 (treated as printing).
  - `reg_wr` = `mem_wr` = 0, `busy` = 0, `req_ready` = 1 once reset is released.
  - `reg_addr`, `reg_data`, `mem_addr`, `mem_data` = 0.
  - Reset mid-operation discards all buffered entries. No partial strobe is emitted.

## Timing
- All outputs are registered on `posedge clk`, except `req_ready` (combinational from count).
- Push to `fifo_count` increment: 1 cycle.
- `printting` falling to first strobe: 2 sync cycles + IDLE→LOAD→WRITE, so the strobe is high in the 4th cycle after the edge is sampled.
- Commit throughput: 1 write per 3 cycles.
- Strobes are 1-cycle pulses. Addr/data are stable from LOAD through HOLD, i.e. 1 cycle before and 1 cycle after the strobe.
- `reg_wr` and `mem_wr` are never high together.
- `fifo_count` decrements in the LOAD cycle.

## Test plan
- **Reset:** hold `reset` = 0 with random inputs → all strobes 0, `fifo_count` 0, `busy` 0; `req_ready` = 1 after release.
- **Push during active scan:** `printting` = 1, push 3 requests (sel 0/1/0, addr 5/100/7, data A/B/C) → no strobe. `printting` → 0 → `reg_wr`@5 = A, `mem_wr`@100 = B, `reg_wr`@7 = C, strobes 3 cycles apart, `fifo_count` ends at 0.
- **Full FIFO:** 8 pushes with `printting` = 1 → `req_ready` = 0, `fifo_count` = 8. A 9th held request is not lost: it is accepted on the first pop, and all 9 commit in order (pointer wrap exercised).
- **Blanking ends mid-commit:** `printting` rises during WRITE of entry 2 of 4 → entry 2 completes, entries 3–4 stay queued (`fifo_count` = 2) until the next blanking.
- **Simultaneous push/pop:** push in the LOAD cycle → `fifo_count` unchanged that cycle, and order is preserved.
- **Reset mid-operation:** assert `reset` during WRITE → strobe drops immediately, `fifo_count` 0, and no write is issued after release.
